// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the float32 adder-tree feeder.
package adder_tree_pkg;

   localparam int DEF_NUM_ELEMENTS = 52;
   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_TREE_LATENCY = 6;
   localparam int DEF_RESULT_DEPTH = 2;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int DEF_CNT_W = count_width(DEF_NUM_ELEMENTS);

   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0] sum;
      logic [DEF_CNT_W-1:0]      count;
   } result_t;

endpackage

// File: rtl/adder_tree_result_fifo.sv
// First-word-fall-through result FIFO; head word is visible whenever non-empty.
module adder_tree_result_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 38,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_push = push_i && (count_q != FULL_CNT);
   assign do_pop  = pop_i && (count_q != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ptr_next(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/adder_tree_feeder.sv
// Packs a serial float32 stream into the adder tree's terms vector and collects
// one tree sum per frame into a small result FIFO after the fixed tree latency.
module adder_tree_feeder
   import adder_tree_pkg::*;
#(
   parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int TREE_LATENCY = DEF_TREE_LATENCY,
   parameter int RESULT_DEPTH = DEF_RESULT_DEPTH,
   parameter int CNT_W        = count_width(NUM_ELEMENTS)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [DATA_WIDTH-1:0]                  s_tdata,
   input  logic                                   s_tvalid,
   input  logic                                   s_tlast,
   output logic                                   s_tready,
   output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] terms_o,
   input  logic [DATA_WIDTH-1:0]                  tree_s_i,
   output logic [DATA_WIDTH-1:0]                  m_tdata,
   output logic [CNT_W-1:0]                       m_tuser,
   output logic                                   m_tvalid,
   input  logic                                   m_tready,
   output logic                                   busy_o
);
   localparam int IF_W = $clog2(RESULT_DEPTH + 1);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_ELEMENTS - 1);
   localparam logic [IF_W:0]    DEPTH_LIM = (IF_W + 1)'(RESULT_DEPTH);
   localparam logic [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(FP_ZERO);

   logic [CNT_W-1:0]                        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]                   fill_q [NUM_ELEMENTS];
   logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] terms_q;
   logic [TREE_LATENCY:0]                   dl_vld_q;
   logic [CNT_W-1:0]                        dl_cnt_q [TREE_LATENCY+1];
   logic [IF_W-1:0]                         in_flight_q, in_flight_d;
   logic [IF_W-1:0]                         fifo_count_w;
   logic                                    fifo_empty_w;
   logic                                    accept_w, close_w, push_w, pop_w;
   logic [DATA_WIDTH+CNT_W-1:0]             push_data_w, head_w;

   // Credit check ignores a same-cycle pop, so a push can never meet a full FIFO.
   assign s_tready    = ({1'b0, in_flight_q} + {1'b0, fifo_count_w}) < DEPTH_LIM;
   assign accept_w    = s_tvalid && s_tready;
   assign close_w     = accept_w && (s_tlast || (idx_q == LAST_IDX));
   assign push_w      = dl_vld_q[TREE_LATENCY];
   assign pop_w       = m_tvalid && m_tready;
   assign push_data_w = {tree_s_i, dl_cnt_q[TREE_LATENCY]};

   always_comb begin
      idx_d = idx_q;
      if (close_w)       idx_d = '0;
      else if (accept_w) idx_d = idx_q + CNT_W'(1);
      in_flight_d = in_flight_q + IF_W'(close_w) - IF_W'(push_w);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q       <= '0;
         in_flight_q <= '0;
         terms_q     <= '0;
         dl_vld_q    <= '0;
         for (int i = 0; i < NUM_ELEMENTS; i++) fill_q[i] <= '0;
         for (int k = 0; k <= TREE_LATENCY; k++) dl_cnt_q[k] <= '0;
      end else begin
         idx_q       <= idx_d;
         in_flight_q <= in_flight_d;
         if (accept_w && !close_w) fill_q[idx_q] <= s_tdata;
         // Launch: stale fill entries beyond the closing beat become +0.0.
         if (close_w) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
               if (CNT_W'(i) < idx_q)       terms_q[i] <= fill_q[i];
               else if (CNT_W'(i) == idx_q) terms_q[i] <= s_tdata;
               else                         terms_q[i] <= PAD;
            end
         end
         dl_vld_q    <= {dl_vld_q[TREE_LATENCY-1:0], close_w};
         dl_cnt_q[0] <= idx_q + CNT_W'(1);
         for (int k = 1; k <= TREE_LATENCY; k++) dl_cnt_q[k] <= dl_cnt_q[k-1];
      end
   end

   adder_tree_result_fifo #(
      .DEPTH (RESULT_DEPTH),
      .WIDTH (DATA_WIDTH + CNT_W),
      .CNT_W (IF_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_w),
      .data_i  (push_data_w),
      .pop_i   (pop_w),
      .data_o  (head_w),
      .empty_o (fifo_empty_w),
      .count_o (fifo_count_w)
   );

   assign terms_o  = terms_q;
   assign m_tdata  = head_w[DATA_WIDTH+CNT_W-1:CNT_W];
   assign m_tuser  = head_w[CNT_W-1:0];
   assign m_tvalid = !fifo_empty_w;
   assign busy_o   = (idx_q != '0) || (in_flight_q != '0) || !fifo_empty_w;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Bench for adder_tree_feeder: behavioural tree model plus an in-order result scoreboard.
module tb_adder_tree_feeder;
   import adder_tree_pkg::*;

   localparam int NE = 52;
   localparam int DW = 32;
   localparam int TL = 6;
   localparam int RD = 2;
   localparam int CW = count_width(NE);

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [DW-1:0]           s_tdata = '0;
   logic                    s_tvalid = 1'b0;
   logic                    s_tlast = 1'b0;
   logic                    s_tready;
   logic [NE-1:0][DW-1:0]   terms_o;
   logic [DW-1:0]           tree_s_i;
   logic [DW-1:0]           m_tdata;
   logic [CW-1:0]           m_tuser;
   logic                    m_tvalid;
   logic                    m_tready = 1'b1;
   logic                    busy_o;

   int total = 0;
   int passed = 0;
   result_t exp_q[$];

   always #5 clk = ~clk;

   adder_tree_feeder dut (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .terms_o  (terms_o),
      .tree_s_i (tree_s_i),
      .m_tdata  (m_tdata),
      .m_tuser  (m_tuser),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .busy_o   (busy_o)
   );

   // Stimulus terms are small non-negative integers, so float sums are exact.
   function automatic int f2i(input logic [31:0] f);
      int e;
      logic [23:0] m;
      if (f[30:23] == 8'd0) return 0;
      e = int'(f[30:23]) - 127;
      m = {1'b1, f[22:0]};
      if (e < 0 || e > 23) return 0;
      return int'(m >> (23 - e));
   endfunction

   function automatic logic [31:0] i2f(input int v);
      int msb;
      logic [31:0] sh;
      msb = 0;
      if (v <= 0) return 32'h0;
      for (int b = 0; b < 24; b++) if (v[b]) msb = b;
      sh = 32'(v) << (23 - msb);
      return {1'b0, 8'(127 + msb), sh[22:0]};
   endfunction

   // Tree model: sum of all terms, appearing TL edges after terms_o changes.
   logic [DW-1:0] tree_pipe [TL];
   always @(posedge clk) begin
      int acc;
      acc = 0;
      for (int i = 0; i < NE; i++) acc += f2i(terms_o[i]);
      tree_pipe[0] <= i2f(acc);
      for (int k = 1; k < TL; k++) tree_pipe[k] <= tree_pipe[k-1];
   end
   assign tree_s_i = tree_pipe[TL-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s got=%0h want=%0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      result_t e;
      if (!rst && m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_result got=%h/%0d want=none", m_tdata, m_tuser);
         end else begin
            e = exp_q.pop_front();
            chk("result_sum", 64'(m_tdata), 64'(e.sum));
            chk("result_cnt", 64'(m_tuser), 64'(e.count));
         end
      end
      if (!rst && dut.push_w && (dut.fifo_count_w == 2'(RD))) begin
         total++;
         $display("FAIL fifo_overflow got=push_on_full want=no_push");
      end
   end

   task automatic send_beat(input logic [31:0] d, input bit last);
      int waited;
      waited = 0;
      s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
      while (!s_tready && waited < 300) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!s_tready) begin
         total++;
         $display("FAIL send_timeout got=stalled want=accept");
         s_tvalid = 1'b0; s_tlast = 1'b0;
         return;
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_vals(input logic [31:0] vals[$], input bit tlast_end);
      for (int i = 0; i < vals.size(); i++)
         send_beat(vals[i], tlast_end && (i == vals.size() - 1));
   endtask

   // Frame rule: a frame ends on tlast or on its NE-th term.
   function automatic void model_push(input logic [31:0] vals[$]);
      int acc, cnt;
      acc = 0; cnt = 0;
      for (int i = 0; i < vals.size(); i++) begin
         acc += f2i(vals[i]);
         cnt++;
         if (i == vals.size() - 1 || cnt == NE) begin
            exp_q.push_back('{sum: i2f(acc), count: CW'(cnt)});
            acc = 0; cnt = 0;
         end
      end
   endfunction

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_remaining", 64'(exp_q.size()), 64'd0);
   endtask

   typedef struct {
      int          n;
      int          base;
      int          step;
      logic [31:0] sum;
      int          cnt;
   } vec_t;

   initial begin
      vec_t tbl[3];
      logic [31:0] vals[$];
      int lat, bad, seen;
      bit done;

      tbl[0] = '{52, 1, 0, 32'h4250_0000, 52};
      tbl[1] = '{3,  1, 1, 32'h40C0_0000, 3};
      tbl[2] = '{1,  5, 0, 32'h40A0_0000, 1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_m_tdata",  64'(m_tdata),  64'd0);
      chk("rst_m_tuser",  64'(m_tuser),  64'd0);
      chk("rst_busy",     64'(busy_o),   64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd1);
      chk("rst_terms_zero", 64'(terms_o == '0), 64'd1);

      for (int t = 0; t < 3; t++) begin
         vals.delete();
         for (int k = 0; k < tbl[t].n; k++) vals.push_back(i2f(tbl[t].base + k * tbl[t].step));
         exp_q.push_back('{sum: tbl[t].sum, count: CW'(tbl[t].cnt)});
         send_vals(vals, 1'b1);
         lat = 0;
         while (!m_tvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         chk("latency", 64'(lat), 64'(TL + 1));
         bad = 0;
         for (int i = 0; i < NE; i++)
            if (terms_o[i] !== ((i < tbl[t].n) ? vals[i] : 32'h0)) bad++;
         chk("terms_layout_bad", 64'(bad), 64'd0);
         wait_drain(50);
      end

      // Full frame without tlast, then an 8-term remainder.
      vals.delete();
      for (int k = 0; k < 60; k++) vals.push_back(32'h3F80_0000);
      exp_q.push_back('{sum: 32'h4250_0000, count: CW'(52)});
      exp_q.push_back('{sum: 32'h4100_0000, count: CW'(8)});
      send_vals(vals, 1'b1);
      wait_drain(100);

      // Backpressure: two frames fill the credits, the third stalls until pops.
      m_tready = 1'b0;
      exp_q.push_back('{sum: 32'h4040_0000, count: CW'(3)});
      exp_q.push_back('{sum: 32'h40C0_0000, count: CW'(3)});
      exp_q.push_back('{sum: 32'h4140_0000, count: CW'(3)});
      vals = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
      send_vals(vals, 1'b1);
      vals = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
      send_vals(vals, 1'b1);
      chk("stall_s_tready", 64'(s_tready), 64'd0);
      vals = '{32'h4080_0000, 32'h4080_0000, 32'h4080_0000};
      fork
         send_vals(vals, 1'b1);
         begin
            repeat (12) @(posedge clk);
            #2;
            chk("stall_still", 64'(s_tready), 64'd0);
            chk("stall_head_valid", 64'(m_tvalid), 64'd1);
            chk("stall_head_data", 64'(m_tdata), 64'h4040_0000);
            chk("stall_busy", 64'(busy_o), 64'd1);
            m_tready = 1'b1;
         end
      join
      wait_drain(100);

      // Reset with one frame in flight and a partial frame filling.
      vals.delete();
      for (int k = 0; k < 8; k++) vals.push_back(32'h3F80_0000);
      send_vals(vals, 1'b1);
      send_beat(32'h3F80_0000, 1'b0);
      send_beat(32'h3F80_0000, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("post_rst_busy", 64'(busy_o), 64'd0);
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (m_tvalid) seen++;
      end
      chk("post_rst_no_stale", 64'(seen), 64'd0);
      exp_q.push_back('{sum: 32'h3F80_0000, count: CW'(1)});
      send_beat(32'h3F80_0000, 1'b1);
      wait_drain(50);

      // Randomized frames with random output backpressure.
      done = 1'b0;
      fork
         begin
            for (int f = 0; f < 30; f++) begin
               vals.delete();
               for (int k = 0, len = int'($urandom_range(1, 70)); k < len; k++)
                  vals.push_back(i2f(int'($urandom_range(0, 15))));
               model_push(vals);
               send_vals(vals, 1'b1);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               m_tready = 1'($urandom_range(0, 1));
            end
         end
      join
      m_tready = 1'b1;
      wait_drain(500);
      repeat (2) @(posedge clk);
      #1 chk("final_idle", 64'(busy_o), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "bench did not terminate");
   end

endmodule
